// File: rtl/skid_slice32.sv
`default_nettype none
// ============================================================================
//  Module   : skid_slice32
//  Purpose  : 32-bit valid/ready register slice with a two-entry skid buffer;
//             all outputs registered. Optional stall counter behind the macro
//             SKID_SLICE32_STAT_EN (adds the stall_cnt port).
//  Revision : 1.0 - initial release
// ============================================================================
module skid_slice32 #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RST_DATA = 32'h0000_0000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [1:0]        occupancy
`ifdef SKID_SLICE32_STAT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    generate
        if (DATA_W != 32) begin : g_width_check
            $error("skid_slice32: DATA_W must be 32");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              m_valid_q, m_valid_d;
    logic              s_ready_q, s_ready_d;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = s_valid & s_ready_q;
    assign w_out_xfer = m_valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            c_ST_EMPTY: begin
                if (w_in_xfer) begin
                    main_d  = s_data;
                    state_d = c_ST_ONE;
                end
            end
            c_ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    main_d = s_data;
                end else if (w_in_xfer) begin
                    skid_d  = s_data;
                    state_d = c_ST_FULL;
                end else if (w_out_xfer) begin
                    state_d = c_ST_EMPTY;
                end
            end
            c_ST_FULL: begin
                if (w_out_xfer) begin
                    main_d  = skid_q;
                    state_d = c_ST_ONE;
                end
            end
            default: state_d = c_ST_EMPTY;
        endcase
        // Handshake flags are derived from the next state so both stay pure flop outputs
        m_valid_d = (state_d != c_ST_EMPTY);
        s_ready_d = (state_d != c_ST_FULL);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= c_ST_EMPTY;
            main_q    <= RST_DATA;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_data    = main_q;
    assign occupancy = state_q;

`ifdef SKID_SLICE32_STAT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_skid_slice32.sv
`default_nettype none
// Testbench for skid_slice32: directed and random valid/ready traffic checked
// against a queue-based reference of the slice.
module tb_skid_slice32;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data  = 32'h0;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready = 1'b0;
    logic [1:0]  occupancy;
`ifdef SKID_SLICE32_STAT_EN
    logic [15:0] stall_cnt;
`endif

    skid_slice32 #(.DATA_W(32), .RST_DATA(32'h0000_0000)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .occupancy (occupancy)
`ifdef SKID_SLICE32_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference: the slice is a 2-deep FIFO whose head is shown on m_data
    logic [31:0] mdl_q[$];
    logic        mdl_s_ready = 1'b0;
    logic [31:0] mdl_last    = 32'h0;
    int unsigned mdl_stall   = 0;
    int unsigned n_in        = 0;
    int unsigned n_out       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit acc_in, acc_out;
        if (rst) begin
            mdl_q.delete();
            mdl_s_ready = 1'b0;
            mdl_last    = 32'h0;
            mdl_stall   = 0;
        end else begin
            acc_in  = s_valid && mdl_s_ready;
            acc_out = (mdl_q.size() > 0) && m_ready;
            if ((mdl_q.size() > 0) && !m_ready && mdl_stall < 32'hFFFF) mdl_stall++;
            if (acc_out) begin
                void'(mdl_q.pop_front());
                n_out++;
            end
            if (acc_in) begin
                mdl_q.push_back(s_data);
                n_in++;
            end
            mdl_s_ready = (mdl_q.size() < 2);
            if (mdl_q.size() > 0) mdl_last = mdl_q[0];
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".m_valid"},   {31'h0, m_valid},   {31'h0, mdl_q.size() > 0});
        check({tag, ".s_ready"},   {31'h0, s_ready},   {31'h0, mdl_s_ready});
        check({tag, ".occupancy"}, {30'h0, occupancy}, mdl_q.size());
        check({tag, ".m_data"},    m_data,             mdl_last);
`ifdef SKID_SLICE32_STAT_EN
        check({tag, ".stall_cnt"}, {16'h0, stall_cnt}, mdl_stall);
`endif
    endtask

    task automatic cycle(input string tag, input logic r, input logic v,
                         input logic [31:0] d, input logic mr);
        rst     = r;
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        model_step();
        @(posedge clk_sys);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held 3 clocks with a word offered
        for (int i = 0; i < 3; i++) begin
            cycle("reset", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
            check("reset.m_data_zero", m_data, 32'h0);
        end
        cycle("release", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check("release.s_ready_up", {31'h0, s_ready}, 32'h1);
        check("release.no_word", {31'h0, m_valid}, 32'h0);
        cycle("release2", 1'b0, 1'b0, 32'h0, 1'b1);
        cycle("release3", 1'b0, 1'b0, 32'h0, 1'b1);

        // Streaming 1..8 with m_ready held high
        for (int i = 1; i <= 8; i++) begin
            cycle("stream", 1'b0, 1'b1, i, 1'b1);
            check("stream.word", m_data, i);
            check("stream.occ1", {30'h0, occupancy}, 32'h1);
        end
        cycle("stream_tail", 1'b0, 1'b0, 32'h0, 1'b1);
        check("stream.drained", {31'h0, m_valid}, 32'h0);

        // Backpressure fill
        cycle("bp_a", 1'b0, 1'b1, 32'hA, 1'b0);
        check("bp.occ_a", {30'h0, occupancy}, 32'h1);
        cycle("bp_b", 1'b0, 1'b1, 32'hB, 1'b0);
        check("bp.occ_b", {30'h0, occupancy}, 32'h2);
        check("bp.s_ready_low", {31'h0, s_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_c_blocked", 1'b0, 1'b1, 32'hC, 1'b0);
            check("bp.hold_a", m_data, 32'hA);
        end
        cycle("bp_drain1", 1'b0, 1'b1, 32'hC, 1'b1);
        check("bp.out_b", m_data, 32'hB);
        cycle("bp_drain2", 1'b0, 1'b1, 32'hC, 1'b1);
        check("bp.out_c", m_data, 32'hC);
        cycle("bp_drain3", 1'b0, 1'b0, 32'h0, 1'b1);
        check("bp.empty", {31'h0, m_valid}, 32'h0);

`ifdef SKID_SLICE32_STAT_EN
        // Stall counter: 5 stall clocks, then saturation from 16'hFFFE
        cycle("st_rst", 1'b1, 1'b0, 32'h0, 1'b0);
        cycle("st_load", 1'b0, 1'b0, 32'h0, 1'b0);
        cycle("st_load2", 1'b0, 1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 5; i++) cycle("stall", 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall.five", {16'h0, stall_cnt}, 32'd5);
        dut.stall_cnt_q = 16'hFFFE;
        mdl_stall       = 32'hFFFE;
        for (int i = 0; i < 3; i++) cycle("stall_sat", 1'b0, 1'b0, 32'h0, 1'b0);
        check("stall.saturate", {16'h0, stall_cnt}, 32'h0000_FFFF);
        cycle("st_drain", 1'b0, 1'b0, 32'h0, 1'b1);
`endif

        // Random valid/ready traffic
        for (int i = 0; i < 10000; i++) begin
            cycle("random", 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) cycle("rand_drain", 1'b0, 1'b0, 32'h0, 1'b1);
        check("random.no_loss", n_out, n_in);

        // Reset mid-operation with two words held
        cycle("mid_fill1", 1'b0, 1'b1, 32'h1111_1111, 1'b0);
        cycle("mid_fill2", 1'b0, 1'b1, 32'h2222_2222, 1'b0);
        check("mid.occ2", {30'h0, occupancy}, 32'h2);
        cycle("mid_rst", 1'b1, 1'b0, 32'h0, 1'b1);
        check("mid.m_valid0", {31'h0, m_valid}, 32'h0);
        check("mid.occ0", {30'h0, occupancy}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle("mid_after", 1'b0, 1'b0, 32'h0, 1'b1);
            check("mid.no_emit", {31'h0, m_valid}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
